// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage feeding the instruction decoder. It owns the program
// counter, reads one instruction word at a time from instruction memory over a
// request/valid interface, and presents it to the decoder with the
// triggered / trigger / indicate_busy handshake. Supports PC redirect
// (branch/jump), a level halt that gates new fetches, and discarding of a stale
// memory response that belongs to a read issued before a redirect.
//
// Parameters
//   INSTR_WIDTH  instruction word width (decoder OP_WIDTH + 2*REG_WIDTH)
//   ADDR_WIDTH   PC / memory word-address width
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   mem_rd       one-cycle read request (issued from the FETCH state)
//   mem_addr     read address, always the current PC
//   mem_rdata    read data, sampled only with mem_valid
//   mem_valid    read data valid, exactly one per request, latency >= 1
//   instr        instruction presented to the decoder
//   triggered    instruction valid towards the decoder
//   dec_ready    decoder is free (decoder's trigger output)
//   dec_busy     decoder has accepted the instruction (indicate_busy)
//   redirect_en  single-cycle pulse: load redirect_pc into the PC
//   redirect_pc  redirect target
//   halt         level; blocks new fetches only
//   pc           current PC
//   fetch_count  instructions handed to the decoder, wraps
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          INSTR_WIDTH = 16,
  parameter int          ADDR_WIDTH  = 8,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   triggered,
  input  logic                   dec_ready,
  input  logic                   dec_busy,
  input  logic                   redirect_en,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [15:0]            fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_WIDTH-1:0]    pc_q;
  logic [ADDR_WIDTH-1:0]    pc_nxt;
  logic [15:0]              cnt_q;
  logic [15:0]              cnt_nxt;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic [INSTR_WIDTH-1:0]   instr_nxt;
  logic                     discard_q;
  logic                     discard_nxt;
  logic                     issue_rd;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc_q      <= RESET_ADDR;
      cnt_q     <= '0;
      instr_q   <= '0;
      discard_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      cnt_q     <= cnt_nxt;
      instr_q   <= instr_nxt;
      discard_q <= discard_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    cnt_nxt     = cnt_q;
    instr_nxt   = instr_q;
    discard_nxt = discard_q;
    issue_rd    = 1'b0;

    case (state)
      S_FETCH: begin
        // A redirect in FETCH suppresses the read: the address on mem_addr is
        // about to change, and issuing it would leave a response for a PC we
        // no longer want.
        if (redirect_en) begin
          pc_nxt = redirect_pc;
        end else if (!halt) begin
          issue_rd  = 1'b1;
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_en) begin
          pc_nxt = redirect_pc;
          if (mem_valid) begin
            // The response arrives together with the redirect: drop it here,
            // nothing remains outstanding.
            discard_nxt = 1'b0;
            state_nxt   = S_FETCH;
          end else begin
            // The read is still in flight; its response must be thrown away.
            discard_nxt = 1'b1;
          end
        end else if (mem_valid) begin
          if (discard_q) begin
            discard_nxt = 1'b0;
            state_nxt   = S_FETCH;
          end else begin
            instr_nxt = mem_rdata;
            state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // The decoder accepted even when a redirect wins the same cycle, so the
        // count moves regardless; only the PC increment yields to the redirect.
        if (dec_busy) begin
          cnt_nxt = cnt_q + 16'd1;
        end
        if (redirect_en) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_FETCH;
        end else if (dec_busy) begin
          pc_nxt    = pc_q + ADDR_WIDTH'(1);
          state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (redirect_en) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_FETCH;
        end else if (dec_ready && !dec_busy) begin
          state_nxt = S_FETCH;
        end
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The read request is decoded in the FETCH cycle itself so that a read goes
  // out in the very first cycle after reset release; rst_n keeps it low while
  // reset is held.
  assign mem_rd      = rst_n & issue_rd;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign triggered   = (state == S_ISSUE);
  assign fetch_count = cnt_q;

endmodule
